// File: rtl/xpb_table_gen_pkg.sv
// rtl/xpb_table_gen_pkg.sv - shared types and constants for the XPB table writer
// Contents:
//   xpb_state_e      sequencer states IDLE / DOUBLE / ACCUM / FINISH
//   XPB_W            default modulus / entry width
//   XPB_D            default digit width (table depth 2^D)
//   XPB_KW           default offset width
//   XPB_NUM_ENTRIES  default table depth
package xpb_gen_pkg;

  localparam int XPB_W           = 1024;
  localparam int XPB_D           = 5;
  localparam int XPB_KW          = 11;
  localparam int XPB_NUM_ENTRIES = 1 << XPB_D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOUBLE = 2'd1,
    ACCUM  = 2'd2,
    FINISH = 2'd3
  } xpb_state_e;

endpackage

// File: rtl/xpb_table_gen_if.sv
// rtl/xpb_table_gen_if.sv - command and table-write bundle of the XPB table writer
// Signals:
//   start    request pulse, honoured only while idle
//   modulus  N, sampled on an accepted start
//   offset   K, sampled on an accepted start
//   busy     generation in progress
//   wr_en    table write strobe
//   wr_addr  table entry index j
//   wr_data  entry value j*(2^K mod N) mod N
//   done     one-cycle pulse after the last write
// Modports: master = generator side, slave = requester / table side.
interface xpb_table_gen_if
  import xpb_gen_pkg::*;
#(
  parameter int W  = XPB_W,
  parameter int D  = XPB_D,
  parameter int KW = XPB_KW
) ();

  logic          start;
  logic [W-1:0]  modulus;
  logic [KW-1:0] offset;
  logic          busy;
  logic          wr_en;
  logic [D-1:0]  wr_addr;
  logic [W-1:0]  wr_data;
  logic          done;

  modport master (
    input  start, modulus, offset,
    output busy, wr_en, wr_addr, wr_data, done
  );

  modport slave (
    output start, modulus, offset,
    input  busy, wr_en, wr_addr, wr_data, done
  );

endinterface

// File: rtl/xpb_table_gen_mod_add.sv
// rtl/xpb_table_gen_mod_add.sv - combinational (a + b) mod n for a, b < n
// Ports:
//   a, b  addends, both already reduced below n
//   n     modulus
//   sum   (a + b) mod n
module mod_add
  import xpb_gen_pkg::*;
#(
  parameter int W = XPB_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] sum
);

  // One carry bit is enough: a + b < 2n, so a single subtract reduces it.
  logic [W:0] s;
  logic [W:0] t;

  assign s   = {1'b0, a} + {1'b0, b};
  assign t   = s - {1'b0, n};
  assign sum = (s >= {1'b0, n}) ? t[W-1:0] : s[W-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// rtl/xpb_table_gen.sv - runtime writer of the XPB reduction lookup table
// Computes base = 2^K mod N by K modular doublings, then writes
// entry[j] = j*base mod N for j = 0..2^D-1 through the write port.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    xpb_table_gen_if master: start/modulus/offset in,
//          busy/wr_en/wr_addr/wr_data/done out (all registered)
module xpb_table_gen
  import xpb_gen_pkg::*;
#(
  parameter int W  = XPB_W,
  parameter int D  = XPB_D,
  parameter int KW = XPB_KW
) (
  input  logic            clk,
  input  logic            reset,
  xpb_table_gen_if.master bus
);

  xpb_state_e    state_q, state_d;
  logic [W-1:0]  n_r_q, n_r_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [D-1:0]  j_q, j_d;
  logic          busy_q, busy_d;
  logic          wr_en_q, wr_en_d;
  logic [D-1:0]  wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic          done_q, done_d;

  logic [W-1:0]  add_a;
  logic [W-1:0]  add_sum;

  // DOUBLE and ACCUM never overlap, so one adder serves both:
  // (x, x) while doubling, (acc, x) while accumulating.
  assign add_a = (state_q == ACCUM) ? acc_q : x_q;

  mod_add #(.W(W)) u_mod_add (
    .a   (add_a),
    .b   (x_q),
    .n   (n_r_q),
    .sum (add_sum)
  );

  always_comb begin
    state_d   = state_q;
    n_r_d     = n_r_q;
    x_d       = x_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q is the visible tail of FINISH; a start coinciding with it
        // is refused so a request never overlaps the completion pulse.
        if (bus.start && !done_q) begin
          n_r_d   = bus.modulus;
          cnt_d   = bus.offset;
          x_d     = W'(1);
          acc_d   = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = (bus.offset != '0) ? DOUBLE : ACCUM;
        end
      end

      DOUBLE: begin
        x_d   = add_sum;
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) begin
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        wr_en_d   = 1'b1;
        wr_addr_d = j_q;
        wr_data_d = acc_q;
        acc_d     = add_sum;
        j_d       = j_q + D'(1);
        if (j_q == {D{1'b1}}) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      n_r_q     <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_r_q     <= n_r_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// tb/tb_xpb_table_gen.sv - self-checking bench for xpb_table_gen
module tb_xpb_table_gen;
  import xpb_gen_pkg::*;

  localparam int NE = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  xpb_table_gen_if #(.W(16),   .D(5), .KW(11)) bus16 ();
  xpb_table_gen_if #(.W(1024), .D(5), .KW(11)) bus1k ();

  xpb_table_gen #(.W(16),   .D(5), .KW(11)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  xpb_table_gen #(.W(1024), .D(5), .KW(11)) dut1k (.clk(clk), .reset(reset), .bus(bus1k));

  int errors = 0;
  int checks = 0;

  logic [15:0]   q16 [$];
  logic [1023:0] q1k [$];
  logic [15:0]   got16 [NE];
  int            n_wr16 = 0;
  int            n_wr1k = 0;
  logic [15:0]   e16;
  logic [1023:0] e1k;
  logic [1023:0] n_prod;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Scoreboard consumers: every write must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && bus16.wr_en) begin
      if (q16.size() == 0) begin
        check("wr16_unexpected", 1, 0);
      end else begin
        e16 = q16.pop_front();
        check("wr16_addr", bus16.wr_addr, n_wr16 % NE);
        check("wr16_data", bus16.wr_data, e16);
        got16[bus16.wr_addr] = bus16.wr_data;
        n_wr16++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus1k.wr_en) begin
      if (q1k.size() == 0) begin
        check("wr1k_unexpected", 1, 0);
      end else begin
        e1k = q1k.pop_front();
        check("wr1k_addr", bus1k.wr_addr, n_wr1k % NE);
        check("wr1k_data", bus1k.wr_data, e1k);
        n_wr1k++;
      end
    end
  end

  task automatic push16(input logic [15:0] n, input int k);
    logic [63:0] base;
    base = (64'd1 << k) % {48'd0, n};
    for (int j = 0; j < NE; j++) begin
      logic [63:0] v;
      v = (64'(j) * base) % {48'd0, n};
      q16.push_back(v[15:0]);
    end
    n_wr16 = 0;
  endtask

  task automatic push1k(input logic [1023:0] n, input int k);
    logic [2047:0] base;
    base = (2048'd1 << k) % {1024'd0, n};
    for (int j = 0; j < NE; j++) begin
      logic [2047:0] v;
      v = (2048'(j) * base) % {1024'd0, n};
      q1k.push_back(v[1023:0]);
    end
    n_wr1k = 0;
  endtask

  // dist_a / dist_b: cycle indices at which a foreign start is pulsed.
  task automatic run16(input logic [15:0] n, input int k, input int dist_a,
                       input int dist_b, input bit start_on_done);
    int cyc;
    bit seen;
    push16(n, k);
    @(negedge clk);
    bus16.start = 1'b1; bus16.modulus = n; bus16.offset = 11'(k);
    @(negedge clk);
    bus16.start = 1'b0; bus16.modulus = 16'h1235; bus16.offset = 11'd7;
    check("busy16_after_start", bus16.busy, 1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
      bus16.start = 1'b0;
      if (bus16.done) begin
        seen = 1;
      end else if (cyc == dist_a || cyc == dist_b) begin
        bus16.start = 1'b1; bus16.modulus = 16'h8003; bus16.offset = 11'd3;
      end
    end
    check("done16_latency", cyc, k + 33);
    check("busy16_at_done", bus16.busy, 0);
    check("drained16", q16.size(), 0);
    if (start_on_done) begin
      bus16.start = 1'b1; bus16.modulus = 16'h00FF; bus16.offset = 11'd0;
    end
    @(negedge clk);
    #1;
    bus16.start = 1'b0;
    check("done16_pulse", bus16.done, 0);
    repeat (3) @(negedge clk);
    #1;
    check("busy16_idle", bus16.busy, 0);
  endtask

  initial begin
    int cyc;
    bit seen;
    bus16.start = 1'b0; bus16.modulus = '0; bus16.offset = '0;
    bus1k.start = 1'b0; bus1k.modulus = '0; bus1k.offset = '0;
    n_prod = {32{32'hDEADBEEF}};
    n_prod[1023] = 1'b1;

    #2;
    check("rst_busy",    bus16.busy, 0);
    check("rst_wr_en",   bus16.wr_en, 0);
    check("rst_done",    bus16.done, 0);
    check("rst_wr_addr", bus16.wr_addr, 0);
    check("rst_wr_data", bus16.wr_data, 0);
    check("rst_busy1k",  bus1k.busy, 0);
    check("rst_wr_en1k", bus1k.wr_en, 0);
    @(negedge clk);
    reset = 1'b0;

    run16(16'hFFF1, 0, -1, -1, 0);
    check("k0_e1",  got16[1], 16'd1);
    check("k0_e31", got16[31], 16'd31);

    run16(16'hFFF1, 16, -1, -1, 0);
    check("k16_e1",  got16[1], 16'h000F);
    check("k16_e31", got16[31], 16'h01D1);

    run16(16'hFFF1, 20, -1, -1, 0);
    check("k20_e31", got16[31], 16'h1D10);

    run16(16'hFFF1, 28, -1, -1, 0);
    check("k28_e1", got16[1], 16'hF000);
    check("k28_e2", got16[2], 16'hE00F);

    run16(16'hFFF1, 31, -1, -1, 0);

    // Foreign starts during DOUBLE, ACCUM and coincident with done.
    run16(16'hFFF1, 12, 5, 20, 1);
    // Foreign start during the FINISH cycle.
    run16(16'hFFF1, 3, -1, 35, 0);

    // Abort mid-ACCUM after entry 10 has been written.
    push16(16'hFFF1, 0);
    @(negedge clk);
    bus16.start = 1'b1; bus16.modulus = 16'hFFF1; bus16.offset = 11'd0;
    @(negedge clk);
    bus16.start = 1'b0;
    cyc = 0;
    while (n_wr16 < 11 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("wr16_before_reset", n_wr16, 11);
    #2;
    reset = 1'b1;
    #1;
    check("abort_wr_en", bus16.wr_en, 0);
    check("abort_busy",  bus16.busy, 0);
    check("abort_done",  bus16.done, 0);
    q16.delete();
    @(negedge clk);
    reset = 1'b0;
    run16(16'hFFF1, 5, -1, -1, 0);

    // Production-width run.
    push1k(n_prod, 570);
    @(negedge clk);
    bus1k.start = 1'b1; bus1k.modulus = n_prod; bus1k.offset = 11'd570;
    @(negedge clk);
    bus1k.start = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 800) begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus1k.done) seen = 1;
    end
    check("done1k_latency", cyc, 570 + 33);
    check("writes1k", n_wr1k, NE);
    check("drained1k", q1k.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
